// File: rtl/conv_seq_ctrl.sv
// Convolution sequencer: walks output pixels and kernel taps, drives conv_cal control and buffer addresses.
// Optional stall input enabled by defining CONV_SEQ_CTRL_HOLD_EN.
module conv_seq_ctrl #(
    parameter int unsigned weight_width  = 2,
    parameter int unsigned weight_height = 2,
    parameter int unsigned img_width     = 4,
    parameter int unsigned img_height    = 4,
    parameter int unsigned stride        = 1,
    parameter int unsigned result_width  = (img_width - weight_width) / stride + 1,
    parameter int unsigned result_height = (img_height - weight_height) / stride + 1,
    parameter int unsigned mac_lat       = 2,
    parameter int unsigned addr_w        = 8
) (
    input  logic              clk_en,
    input  logic              rst_n,
    input  logic              start,
`ifdef CONV_SEQ_CTRL_HOLD_EN
    input  logic              hold,
`endif
    output logic              busy,
    output logic              done,
    output logic              conv_on,
    output logic              feed_vld,
    output logic              chge_rlt,
    output logic              chge_rlt_q,
    output logic              srh_fin,
    output logic [3:0]        rlt_l,
    output logic [3:0]        rlt_c,
    output logic [addr_w-1:0] img_addr,
    output logic [addr_w-1:0] wei_addr
);

    localparam int unsigned KCW = (weight_width > 1) ? $clog2(weight_width) : 1;
    localparam int unsigned KLW = (weight_height > 1) ? $clog2(weight_height) : 1;
    localparam int unsigned DCW = (mac_lat > 1) ? $clog2(mac_lat) : 1;
    localparam logic [KCW-1:0] KC_LAST = KCW'(weight_width - 1);
    localparam logic [KLW-1:0] KL_LAST = KLW'(weight_height - 1);
    localparam logic [DCW-1:0] DC_LAST = DCW'(mac_lat - 1);
    localparam logic [3:0]     RC_LAST = 4'(result_width - 1);
    localparam logic [3:0]     RL_LAST = 4'(result_height - 1);

    typedef enum logic [2:0] {S_IDLE, S_MAC, S_DRAIN, S_CHG, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [KCW-1:0]   r_kc, w_kc_nxt;
    logic [KLW-1:0]   r_kl, w_kl_nxt;
    logic [DCW-1:0]   r_dc, w_dc_nxt;
    logic [3:0]       r_rc, w_rc_nxt;
    logic [3:0]       r_rl, w_rl_nxt;
    logic             r_busy, r_done, r_conv_on, r_feed_vld, r_chge_rlt, r_chge_rlt_q, r_srh_fin;
    logic             w_busy_nxt, w_done_nxt, w_conv_on_nxt, w_feed_vld_nxt, w_chge_nxt, w_srh_nxt;
    logic [addr_w-1:0] r_img_addr, r_wei_addr, w_img_nxt, w_wei_nxt;
    logic             w_stall;

`ifdef CONV_SEQ_CTRL_HOLD_EN
    assign w_stall = hold && ((r_state == S_MAC) || (r_state == S_DRAIN));
`else
    assign w_stall = 1'b0;
`endif

    // Addresses are formed at 32 bits and truncated; overflowing parameter sets are not supported.
    function automatic logic [addr_w-1:0] calc_img_addr(input logic [3:0] rl, input logic [3:0] rc,
                                                       input logic [KLW-1:0] kl, input logic [KCW-1:0] kc);
        logic [31:0] full;
        full = (32'(rl) * stride + 32'(kl)) * img_width + 32'(rc) * stride + 32'(kc);
        return addr_w'(full);
    endfunction

    function automatic logic [addr_w-1:0] calc_wei_addr(input logic [KLW-1:0] kl, input logic [KCW-1:0] kc);
        logic [31:0] full;
        full = 32'(kl) * weight_width + 32'(kc);
        return addr_w'(full);
    endfunction

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_kc_nxt    = r_kc;
        w_kl_nxt    = r_kl;
        w_dc_nxt    = r_dc;
        w_rc_nxt    = r_rc;
        w_rl_nxt    = r_rl;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_MAC;
                    w_kc_nxt = '0;
                    w_kl_nxt = '0;
                    w_dc_nxt = '0;
                    w_rc_nxt = '0;
                    w_rl_nxt = '0;
                end
            end
            S_MAC: begin
                if (!w_stall) begin
                    if (r_kc == KC_LAST && r_kl == KL_LAST) begin
                        w_state_nxt = S_DRAIN;
                        w_dc_nxt = '0;
                    end else if (r_kc == KC_LAST) begin
                        w_kc_nxt = '0;
                        w_kl_nxt = r_kl + 1'b1;
                    end else begin
                        w_kc_nxt = r_kc + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (!w_stall) begin
                    if (r_dc == DC_LAST) w_state_nxt = S_CHG;
                    else                 w_dc_nxt = r_dc + 1'b1;
                end
            end
            S_CHG: begin
                if (r_rc == RC_LAST && r_rl == RL_LAST) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_MAC;
                    w_kc_nxt = '0;
                    w_kl_nxt = '0;
                    if (r_rc == RC_LAST) begin
                        w_rc_nxt = '0;
                        w_rl_nxt = r_rl + 1'b1;
                    end else begin
                        w_rc_nxt = r_rc + 1'b1;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every port comes straight off a flop.
        w_busy_nxt     = (w_state_nxt != S_IDLE);
        w_done_nxt     = (w_state_nxt == S_DONE);
        w_conv_on_nxt  = !w_stall && ((w_state_nxt == S_MAC) || (w_state_nxt == S_DRAIN) || (w_state_nxt == S_CHG));
        w_feed_vld_nxt = !w_stall && (w_state_nxt == S_MAC);
        w_chge_nxt     = (w_state_nxt == S_CHG);
        w_srh_nxt      = (w_state_nxt == S_CHG) && (w_rc_nxt == RC_LAST) && (w_rl_nxt == RL_LAST);
        w_img_nxt      = calc_img_addr(w_rl_nxt, w_rc_nxt, w_kl_nxt, w_kc_nxt);
        w_wei_nxt      = calc_wei_addr(w_kl_nxt, w_kc_nxt);
    end

    always_ff @(posedge clk_en or negedge rst_n) begin
        if (!rst_n) begin
            r_kc         <= '0;
            r_kl         <= '0;
            r_dc         <= '0;
            r_rc         <= '0;
            r_rl         <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_conv_on    <= 1'b0;
            r_feed_vld   <= 1'b0;
            r_chge_rlt   <= 1'b0;
            r_chge_rlt_q <= 1'b0;
            r_srh_fin    <= 1'b0;
            r_img_addr   <= '0;
            r_wei_addr   <= '0;
        end else begin
            r_kc         <= w_kc_nxt;
            r_kl         <= w_kl_nxt;
            r_dc         <= w_dc_nxt;
            r_rc         <= w_rc_nxt;
            r_rl         <= w_rl_nxt;
            r_busy       <= w_busy_nxt;
            r_done       <= w_done_nxt;
            r_conv_on    <= w_conv_on_nxt;
            r_feed_vld   <= w_feed_vld_nxt;
            r_chge_rlt   <= w_chge_nxt;
            r_chge_rlt_q <= r_chge_rlt;
            r_srh_fin    <= w_srh_nxt;
            r_img_addr   <= w_img_nxt;
            r_wei_addr   <= w_wei_nxt;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign conv_on    = r_conv_on;
    assign feed_vld   = r_feed_vld;
    assign chge_rlt   = r_chge_rlt;
    assign chge_rlt_q = r_chge_rlt_q;
    assign srh_fin    = r_srh_fin;
    assign rlt_l      = r_rl;
    assign rlt_c      = r_rc;
    assign img_addr   = r_img_addr;
    assign wei_addr   = r_wei_addr;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: default 4x4/2x2 instance and a 5x5/3x3 stride-2 instance,
// compared cycle by cycle against a nested-loop trace of the convolution walk.
module tb_conv_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start1, start2;

    logic busy1, done1, conv1, feed1, chg1, chgq1, srh1;
    logic [3:0] rl1, rc1;
    logic [7:0] ia1, wa1;
    logic busy2, done2, conv2, feed2, chg2, chgq2, srh2;
    logic [3:0] rl2, rc2;
    logic [7:0] ia2, wa2;

    conv_seq_ctrl dut1 (
`ifdef CONV_SEQ_CTRL_HOLD_EN
        .hold(1'b0),
`endif
        .clk_en(clk), .rst_n(rst_n), .start(start1),
        .busy(busy1), .done(done1), .conv_on(conv1), .feed_vld(feed1),
        .chge_rlt(chg1), .chge_rlt_q(chgq1), .srh_fin(srh1),
        .rlt_l(rl1), .rlt_c(rc1), .img_addr(ia1), .wei_addr(wa1)
    );

    conv_seq_ctrl #(
        .weight_width(3), .weight_height(3), .img_width(5), .img_height(5), .stride(2)
    ) dut2 (
`ifdef CONV_SEQ_CTRL_HOLD_EN
        .hold(1'b0),
`endif
        .clk_en(clk), .rst_n(rst_n), .start(start2),
        .busy(busy2), .done(done2), .conv_on(conv2), .feed_vld(feed2),
        .chge_rlt(chg2), .chge_rlt_q(chgq2), .srh_fin(srh2),
        .rlt_l(rl2), .rlt_c(rc2), .img_addr(ia2), .wei_addr(wa2)
    );

    // {busy, done, conv_on, feed_vld, chge_rlt, chge_rlt_q, srh_fin, rlt_l, rlt_c, img_addr, wei_addr}
    logic [30:0] obs1, obs2;
    assign obs1 = {busy1, done1, conv1, feed1, chg1, chgq1, srh1, rl1, rc1, ia1, wa1};
    assign obs2 = {busy2, done2, conv2, feed2, chg2, chgq2, srh2, rl2, rc2, ia2, wa2};

    logic [30:0] exp_q[$];
    bit          last_ch;
    int          n_err = 0;
    int          n_chk = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit b, input bit d, input bit c, input bit f, input bit ch, input bit s,
                        input int rl, input int rc, input int ia, input int wa);
        logic [3:0] rl4, rc4;
        logic [7:0] ia8, wa8;
        rl4 = 4'(rl); rc4 = 4'(rc); ia8 = 8'(ia); wa8 = 8'(wa);
        exp_q.push_back({b, d, c, f, ch, last_ch, s, rl4, rc4, ia8, wa8});
        last_ch = ch;
    endtask

    // Expected trace from the cycle after start up to and including the first IDLE cycle.
    task automatic build(input int iw, input int ww, input int wh, input int st, input int lat,
                         input int rw, input int rh);
        int ia, wa;
        exp_q.delete();
        last_ch = 0;
        ia = 0; wa = 0;
        for (int pl = 0; pl < rh; pl++)
            for (int pc = 0; pc < rw; pc++) begin
                for (int kl = 0; kl < wh; kl++)
                    for (int kc = 0; kc < ww; kc++) begin
                        ia = (pl * st + kl) * iw + pc * st + kc;
                        wa = kl * ww + kc;
                        push(1, 0, 1, 1, 0, 0, pl, pc, ia, wa);
                    end
                for (int d = 0; d < lat; d++) push(1, 0, 1, 0, 0, 0, pl, pc, ia, wa);
                push(1, 0, 1, 0, 1, (pl == rh - 1) && (pc == rw - 1), pl, pc, ia, wa);
            end
        push(1, 1, 0, 0, 0, 0, rh - 1, rw - 1, ia, wa);
        push(0, 0, 0, 0, 0, 0, rh - 1, rw - 1, ia, wa);
    endtask

    task automatic set_start(input bit sel, input bit v);
        if (sel) start2 = v;
        else     start1 = v;
    endtask

    // Entered and left at posedge+1. sel picks the instance; repulse sprinkles start while busy.
    task automatic run_seq(input bit sel, input bit repulse, input int iw, input int ww, input int wh,
                           input int st, input int lat);
        int rw, rh, p, total, done_cyc, busy_n, chg_n, srh_n, srh_cyc, last_chg;
        logic [30:0] obs;
        rw = (iw - ww) / st + 1;
        rh = (iw - wh) / st + 1;
        p  = ww * wh + lat + 1;
        build(iw, ww, wh, st, lat, rw, rh);
        total = exp_q.size();
        done_cyc = -1; busy_n = 0; chg_n = 0; srh_n = 0; srh_cyc = -1; last_chg = -1;
        repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
        set_start(sel, 1'b1);
        @(posedge clk); #1;
        set_start(sel, 1'b0);
        for (int k = 1; k <= total; k++) begin
            obs = sel ? obs2 : obs1;
            check_val($sformatf("trace%0d c%0d", sel, k), {33'd0, obs}, {33'd0, exp_q[k-1]});
            if (obs[30]) busy_n++;
            if (obs[29] && done_cyc < 0) done_cyc = k;
            if (obs[26]) begin chg_n++; last_chg = k; end
            if (obs[24]) begin srh_n++; srh_cyc = k; end
            if (k < total) begin
                set_start(sel, repulse ? 1'($urandom_range(0, 1)) : 1'b0);
                @(posedge clk); #1;
            end
        end
        set_start(sel, 1'b0);
        check_val("done_cycle", done_cyc, rw * rh * p + 1);
        check_val("busy_cycles", busy_n, rw * rh * p + 1);
        check_val("chge_count", chg_n, rw * rh);
        check_val("srh_count", srh_n, 1);
        check_val("srh_on_last_chge", srh_cyc, last_chg);
    endtask

    initial begin
        int dn;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0;
        #2;
        check_val("reset_outputs1", {33'd0, obs1}, 64'd0);
        check_val("reset_outputs2", {33'd0, obs2}, 64'd0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        run_seq(1'b0, 1'b0, 4, 2, 2, 1, 2);
        run_seq(1'b0, 1'b1, 4, 2, 2, 1, 2);
        run_seq(1'b1, 1'b0, 5, 3, 3, 2, 2);
        run_seq(1'b1, 1'b1, 5, 3, 3, 2, 2);

        // Abort a run with reset at cycle 20: outputs clear at once and no done follows.
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (19) begin @(posedge clk); #1; end
        check_val("busy_before_abort", busy1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_val("abort_outputs", {33'd0, obs1}, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        dn = 0;
        repeat (60) begin @(posedge clk); #1; dn += int'(done1); end
        check_val("no_done_after_abort", dn, 0);
        check_val("idle_after_abort", busy1, 1'b0);

        run_seq(1'b0, 1'($urandom_range(0, 1)), 4, 2, 2, 1, 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/conv_seq_ctrl.md
Name: conv_seq_ctrl

Overview:
- Sequencer that drives the conv_cal datapath through one full convolution.
- Walks every output pixel (rlt_l, rlt_c) and every kernel tap (k_l, k_c) in row-major order.
- Issues image and weight buffer addresses, and generates conv_on, chge_rlt, chge_rlt_q and srh_fin so the accumulator is cleared and each result is captured.
- Sits between the top-level start/done handshake and the conv_cal and operand buffers.

Parameters:
- weight_width, 2, kernel columns
- weight_height, 2, kernel rows
- img_width, 4, image columns (padded size when padding is used upstream)
- img_height, 4, image rows
- stride, 1, kernel step in both directions
- result_width, (img_width-weight_width)/stride+1, output columns; must be ≤16
- result_height, (img_height-weight_height)/stride+1, output rows; must be ≤16
- mac_lat, 2, multiply-accumulate latency in cycles
- addr_w, 8, buffer address width

Ports:
- clk_en  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a convolution
- busy  output  1  high from the cycle after start is accepted until done drops
- done  output  1  one-cycle completion pulse
- conv_on  output  1  enables accumulation and result write in conv_cal
- feed_vld  output  1  operands valid; when low the datapath muxes img_cal to 0
- chge_rlt  output  1  pixel-boundary accumulator reload pulse
- chge_rlt_q  output  1  chge_rlt delayed one cycle; suppresses the result write
- srh_fin  output  1  last-pixel reload pulse
- rlt_l  output  4  current output row
- rlt_c  output  4  current output column
- img_addr  output  addr_w  (rlt_l*stride+k_l)*img_width + rlt_c*stride + k_c
- wei_addr  output  addr_w  k_l*weight_width + k_c

Behaviour:
- Async reset forces IDLE. All outputs are 0, including all counters.
- Reset mid-operation aborts immediately. No done pulse is issued.
- Every output is registered.
- States: IDLE, MAC, DRAIN, CHG, DONE.
- IDLE:
  - start=1 → MAC next cycle, with all counters at 0.
  - start is ignored in every other state.
- MAC:
  - Outputs: conv_on=1, feed_vld=1; addresses follow the current counters.
  - Counters: k_c increments each cycle; when k_c reaches weight_width-1 it wraps and k_l increments.
  - Exit: after the tap at (weight_height-1, weight_width-1) → DRAIN. MAC lasts weight_width*weight_height cycles.
- DRAIN:
  - Outputs: conv_on=1, feed_vld=0; addresses held.
  - Lasts mac_lat cycles → CHG.
- CHG, one cycle:
  - conv_on=1, chge_rlt=1.
  - srh_fin=1 additionally if rlt_l=result_height-1 and rlt_c=result_width-1.
- Leaving CHG:
  - Not last pixel: rlt_c increments; when rlt_c reaches result_width-1 it wraps to 0 and rlt_l increments. Tap counters clear; → MAC.
  - Last pixel: → DONE.
- chge_rlt_q is chge_rlt registered one extra cycle. It is high in the first MAC cycle of the next pixel and blocks a stale write at the new address.
- DONE, one cycle: done=1, conv_on=0; → IDLE. busy deasserts with the IDLE transition.
- rlt_l and rlt_c hold their last values in IDLE until the next start, then clear.
- Cycles per pixel: P = weight_width*weight_height + mac_lat + 1.
- Timing with start sampled at cycle 0:
  - done is high at cycle result_width*result_height*P + 1.
- Address arithmetic is unsigned and computed at full width before truncation to addr_w. Parameter sets that overflow are illegal.

Optional Feature:
- Macro: CONV_SEQ_CTRL_HOLD_EN.
- When defined:
  - Adds input hold (1 bit).
  - While hold=1 in MAC or DRAIN, state and all counters freeze, feed_vld=0 and conv_on=0.
  - hold has no effect in IDLE, CHG or DONE.
  - Releasing hold resumes at the exact tap where it stopped.
- When undefined: no hold port; the sequence is never stalled.

Test Plan:
- Default parameters, start pulse at cycle 0:
  - 9 pixels, P=7; done at cycle 64, busy high for cycles 1..64.
  - 9 chge_rlt pulses; srh_fin only with the 9th.
- Pixel (1,2) tap sequence → img_addr 6,7,10,11; wei_addr 0,1,2,3; rlt_l=1, rlt_c=2 throughout.
- stride=2 with 5x5 image and 3x3 kernel:
  - 2x2 result, P=12.
  - Pixel (1,1) first img_addr = 12; done at cycle 49.
- chge_rlt_q high exactly one cycle after each chge_rlt. feed_vld=0 in all DRAIN cycles.
- Start re-pulsed while busy → ignored; done timing unchanged.
- Reset asserted at cycle 20 → all outputs 0 asynchronously; no done.
  - A new start after reset runs a full 64-cycle sequence.
- With CONV_SEQ_CTRL_HOLD_EN, hold=1 for 5 cycles during pixel 0 MAC:
  - img_addr frozen, conv_on=0 during hold.
  - done delayed to cycle 69.
